// File: rtl/multdiv_unit.sv
// HI/LO multiply-divide unit: fixed-latency multiply/accumulate, 32-step
// restoring divider with a sign-fixup cycle, and direct HI/LO moves.
package multdiv_pkg;
  typedef enum logic [3:0] {
    OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MTHI, OP_MTLO
  } decoded_op_t;
endpackage

module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int MUL_STAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  decoded_op_t op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t      state;
  decoded_op_t op_q;
  logic [31:0] a_q, b_q;
  logic [4:0]  cnt;
  logic [32:0] rem;
  logic [31:0] quo;

  assign ready_o = (state == IDLE);

  // multiply datapath: operands extended to 64 bits so one product covers signed and unsigned
  logic        mul_signed;
  logic [63:0] ma, mb, prod, hilo, mul_res;

  assign mul_signed = op_q inside {OP_MULT, OP_MADD, OP_MSUB};
  assign ma   = {{32{mul_signed & a_q[31]}}, a_q};
  assign mb   = {{32{mul_signed & b_q[31]}}, b_q};
  assign prod = ma * mb;
  assign hilo = {hi_o, lo_o};

  always_comb begin
    mul_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = hilo + prod;
      OP_MSUB, OP_MSUBU: mul_res = hilo - prod;
      default:           mul_res = prod;
    endcase
  end

  // divide datapath on magnitudes; signs restored in FIX
  logic        div_signed, fits, neg_q, neg_r;
  logic [31:0] a_mag_in, b_mag, q_fix, r_fix;
  logic [32:0] shifted, rem_nxt;

  assign a_mag_in   = (op_i == OP_DIV && a_i[31]) ? -a_i : a_i;
  assign div_signed = (op_q == OP_DIV);
  assign b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;
  assign shifted    = {rem[31:0], quo[31]};
  assign fits       = (shifted >= {1'b0, b_mag});
  assign rem_nxt    = fits ? shifted - {1'b0, b_mag} : shifted;
  assign neg_q      = div_signed && (a_q[31] ^ b_q[31]);
  assign neg_r      = div_signed && a_q[31];
  assign q_fix      = neg_q ? -quo : quo;
  assign r_fix      = neg_r ? -rem[31:0] : rem[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= OP_NONE;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      done_o <= 1'b0;
      hi_o   <= '0;
      lo_o   <= '0;
    end else begin
      done_o <= 1'b0;
      if (flush_i) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (valid_i) begin
            op_q <= op_i;
            a_q  <= a_i;
            b_q  <= b_i;
            cnt  <= '0;
            case (op_i)
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU:
                state <= MUL;
              OP_DIV, OP_DIVU: begin
                state <= DIV;
                rem   <= '0;
                quo   <= a_mag_in;
              end
              OP_MTHI: begin
                hi_o   <= a_i;
                done_o <= 1'b1;
              end
              OP_MTLO: begin
                lo_o   <= a_i;
                done_o <= 1'b1;
              end
              default: done_o <= 1'b1;
            endcase
          end
          MUL: begin
            if (cnt == 5'(MUL_STAGES - 1)) begin
              {hi_o, lo_o} <= mul_res;
              done_o       <= 1'b1;
              state        <= IDLE;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          DIV: begin
            rem <= rem_nxt;
            quo <= {quo[30:0], fits};
            if (cnt == 5'd31) state <= FIX;
            else              cnt   <= cnt + 5'd1;
          end
          FIX: begin
            // divide by zero has a fixed architectural result, independent of sign
            if (b_q == '0) begin
              lo_o <= 32'hFFFF_FFFF;
              hi_o <= a_q;
            end else begin
              lo_o <= q_fix;
              hi_o <= r_fix;
            end
            done_o <= 1'b1;
            state  <= IDLE;
            cnt    <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: products, accumulate, divides, moves,
// flush and reset aborts, with latency and done-pulse checks.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset, valid, flush;
  decoded_op_t op;
  logic [31:0] a, b;
  logic        ready, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc, busy, pulses;

  multdiv_unit #(.MUL_STAGES(3)) dut (
    .clk(clk), .reset(reset), .valid_i(valid), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .ready_o(ready), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // present one request for one edge; returns at the negedge after the accept edge
  task automatic issue(input decoded_op_t o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    valid = 1'b0; op = OP_NONE;
  endtask

  task automatic wait_done(output int c, output int bz);
    c = 0; bz = 0;
    while (!done && c < 100) begin
      if (!ready) bz++;
      @(negedge clk);
      c++;
    end
  endtask

  task automatic count_done(input int n, output int p);
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) p++;
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; flush = 1'b0; op = OP_NONE; a = '0; b = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h1);
    chk("rst_done", {31'b0, done}, 32'h0);
    reset = 1'b0;

    issue(OP_MULT, 32'hFFFF_FFFF, 32'h2);
    wait_done(cyc, busy);
    chk("mult_lat", cyc, 3);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    @(negedge clk);
    chk("mult_done_1cyc", {31'b0, done}, 32'h0);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
    wait_done(cyc, busy);
    chk("multu_lat", cyc, 3);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(OP_DIVU, 32'd100, 32'd7);
    wait_done(cyc, busy);
    chk("divu_lat", cyc, 33);
    chk("divu_busy", busy, 33);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_ready_at_done", {31'b0, ready}, 32'h1);
    @(negedge clk);
    chk("divu_done_1cyc", {31'b0, done}, 32'h0);

    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, busy);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(OP_DIV, 32'd5, 32'd0);
    wait_done(cyc, busy);
    chk("div0_lat", cyc, 33);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, busy);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    issue(OP_MTHI, 32'h0, 32'h0);
    chk("mthi_done", {31'b0, done}, 32'h1);
    chk("mthi_hi", hi, 32'h0);
    issue(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
    chk("mtlo_done", {31'b0, done}, 32'h1);
    chk("mtlo_lo", lo, 32'hFFFF_FFFF);

    issue(OP_MADDU, 32'd1, 32'd1);
    wait_done(cyc, busy);
    chk("maddu_lat", cyc, 3);
    chk("maddu_hi", hi, 32'h1);
    chk("maddu_lo", lo, 32'h0);

    issue(OP_MSUBU, 32'd1, 32'd1);
    wait_done(cyc, busy);
    chk("msubu_hi", hi, 32'h0);
    chk("msubu_lo", lo, 32'hFFFF_FFFF);

    // signed: 0:FFFFFFFF - (-1 * 1) = 1:00000000
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'd1);
    wait_done(cyc, busy);
    chk("msub_hi", hi, 32'h1);
    chk("msub_lo", lo, 32'h0);

    // flush a divide 10 cycles after accept
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_ready", {31'b0, ready}, 32'h1);
    chk("flush_done", {31'b0, done}, 32'h0);
    count_done(40, pulses);
    chk("flush_no_done", pulses, 0);
    chk("flush_hi", hi, 32'h1);
    chk("flush_lo", lo, 32'h0);
    issue(OP_MTLO, 32'h1234, 32'h0);
    chk("post_flush_mtlo", lo, 32'h1234);

    // flush landing on the multiply write edge
    issue(OP_MULT, 32'd7, 32'd9);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    count_done(5, pulses);
    chk("flushwr_no_done", pulses, 0);
    chk("flushwr_hi", hi, 32'h1);
    chk("flushwr_lo", lo, 32'h1234);

    // flush overrides a same-cycle request
    @(negedge clk);
    valid = 1'b1; op = OP_MTLO; a = 32'h5678; flush = 1'b1;
    @(negedge clk);
    valid = 1'b0; op = OP_NONE; flush = 1'b0;
    chk("flushreq_lo", lo, 32'h1234);
    chk("flushreq_done", {31'b0, done}, 32'h0);

    issue(OP_NONE, 32'hDEAD, 32'hBEEF);
    chk("nop_done", {31'b0, done}, 32'h1);
    chk("nop_lo", lo, 32'h1234);

    // asynchronous reset in the middle of a multiply
    issue(OP_MULT, 32'd3, 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_ready", {31'b0, ready}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    count_done(6, pulses);
    chk("midrst_no_done", pulses, 0);
    chk("midrst_lo_after", lo, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 SHALL have parameter MUL_STAGES, default 3, meaning the number of cycles from accepting a multiply-class op to done_o (legal range 1..8).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port valid_i  input  1  request valid from the issue stage.
REQ-005 SHALL have port op_i  input  decoded_op_t  decoded operation (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO).
REQ-006 SHALL have port a_i  input  32  rs operand.
REQ-007 SHALL have port b_i  input  32  rt operand.
REQ-008 SHALL have port flush_i  input  1  pipeline flush (exception/ERET); aborts the in-flight op.
REQ-009 SHALL have port ready_o  output  1  unit idle and able to accept.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse when HI/LO hold the new result.
REQ-011 SHALL have port hi_o  output  32  architectural HI register.
REQ-012 SHALL have port lo_o  output  32  architectural LO register.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, FIX; ready_o = (state == IDLE), combinational from state.
REQ-014 SHALL accept a request on a rising edge where valid_i && ready_o && !flush_i; operands and op are latched internally at that edge.
REQ-015 SHALL ignore valid_i while ready_o is low; the issue stage holds the request.
REQ-016 MULT/MULTU/MADD/MADDU/MSUB/MSUBU SHALL go IDLE->MUL, count MUL_STAGES cycles, write HI:LO on the last one, and return to IDLE.
REQ-017 MULT/MULTU SHALL set HI:LO = 64-bit signed/unsigned product; MADD(U) SHALL set HI:LO += product; MSUB(U) SHALL set HI:LO -= product; all arithmetic modulo 2^64, with HI:LO sampled at the write edge.
REQ-018 DIV/DIVU SHALL go IDLE->DIV, run 32 restoring-division iterations on operand magnitudes (one bit per cycle), then spend one FIX cycle applying signs, writing HI:LO, and returning to IDLE.
REQ-019 DIV SHALL give the quotient the sign of a XOR b and the remainder the sign of a, producing LO = quotient and HI = remainder.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-021 Divide by zero (b = 0, both DIV and DIVU) SHALL give LO = 0xFFFFFFFF and HI = a; it SHALL take the same latency as a normal divide.
REQ-022 MTHI/MTLO SHALL write HI/LO at the accept edge, stay in IDLE, and pulse done_o in the following cycle.
REQ-023 Any other op accepted SHALL leave HI/LO unchanged, stay in IDLE, and pulse done_o in the following cycle.
REQ-024 done_o SHALL be high for exactly the one cycle following the HI/LO write edge.
REQ-025 Latency from accept edge k to the HI/LO write edge SHALL be k+MUL_STAGES for multiply-class ops and k+33 for divides.
REQ-026 flush_i high at any edge SHALL force state to IDLE, cancel any pending write and done_o, and leave HI/LO unchanged; flush_i overrides a same-cycle valid_i.
REQ-027 flush_i on the same edge as a result write SHALL suppress that write.

Reset
REQ-028 While reset is high: state = IDLE, hi_o = 0, lo_o = 0, done_o = 0, ready_o = 1, and internal counters are cleared.
REQ-029 reset asserted mid-operation SHALL abort the op immediately (asynchronously), with no done_o pulse after deassertion.

Verification
REQ-030 MULT a=0xFFFFFFFF b=0x00000002 -> HI=0xFFFFFFFF LO=0xFFFFFFFE, done_o exactly MUL_STAGES cycles after accept; MULTU on the same operands -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-031 DIVU a=100 b=7 -> LO=14 HI=2, ready_o low for 33 cycles, done_o one cycle after the write edge.
REQ-032 DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIV a=5 b=0 -> LO=0xFFFFFFFF HI=5.
REQ-033 With HI:LO preset to 0x00000000:0xFFFFFFFF: MADDU a=1 b=1 -> HI=1 LO=0; then MSUBU a=1 b=1 -> HI=0 LO=0xFFFFFFFF.
REQ-034 Start DIV, assert flush_i 10 cycles after accept -> ready_o=1 next cycle, no done_o, HI/LO unchanged; a new MTLO a=0x1234 is then accepted -> LO=0x1234.
REQ-035 Assert reset during the MUL state -> hi_o=lo_o=0, ready_o=1, and no done_o pulse after release.
